// File: rtl/ascon_ct_decrypt.sv
// ---------------------------------------------------------------------------
// ascon_ct_decrypt
//
// Ciphertext-processing stage of the ASCON decryption path. It loads the
// 320-bit state after associated-data absorption and domain separation, then
// consumes 64-bit ciphertext words over a valid/ready stream. For each word it
// returns the recovered plaintext (x0 ^ ct) and replaces the rate word x0 with
// the ciphertext. Between words it runs a ROUNDS-round permutation, one round
// per clock. After the last word no permutation is run; the state is
// presented on y0..y4 with done=1 for the finalization stage.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               load s0..s4 and begin (honoured in IDLE/DONE only)
//   s0..s4              initial state words
//   ct_valid/ct_ready   ciphertext stream handshake
//   ct_data, ct_last    ciphertext word and final-word marker
//   pt_valid/pt_ready   plaintext stream handshake
//   pt_data             plaintext word, stable while pt_valid=1
//   done                ciphertext phase complete, y0..y4 valid
//   y0..y4              current state words (meaningful while done=1)
// ---------------------------------------------------------------------------
module ascon_ct_decrypt #(
    parameter int ROUNDS = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] s0,
    input  logic [63:0] s1,
    input  logic [63:0] s2,
    input  logic [63:0] s3,
    input  logic [63:0] s4,
    input  logic        ct_valid,
    output logic        ct_ready,
    input  logic [63:0] ct_data,
    input  logic        ct_last,
    output logic        pt_valid,
    input  logic        pt_ready,
    output logic [63:0] pt_data,
    output logic        done,
    output logic [63:0] y0,
    output logic [63:0] y1,
    output logic [63:0] y2,
    output logic [63:0] y3,
    output logic [63:0] y4
);

    // Round index of the first round is 12-ROUNDS; the last round uses rnd=ROUNDS-1.
    localparam logic [3:0] RC_BASE  = 4'(12 - ROUNDS);
    localparam logic [2:0] RND_LAST = 3'(ROUNDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_CT = 3'd1,
        ST_PT_HOLD = 3'd2,
        ST_PERM    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t state_r;
    state_t state_s;

    logic [63:0] x0_r;
    logic [63:0] x1_r;
    logic [63:0] x2_r;
    logic [63:0] x3_r;
    logic [63:0] x4_r;
    logic [2:0]  rnd_r;
    logic        last_r;
    logic [63:0] pt_data_r;
    logic        ct_ready_r;
    logic        pt_valid_r;
    logic        done_r;

    logic            start_ok_s;
    logic            ct_fire_s;
    logic            pt_fire_s;
    logic [3:0]      rc_idx_s;
    logic [7:0]      rc_s;
    logic [4:0][63:0] round_s;

    // 64-bit rotate right by a constant amount.
    function automatic logic [63:0] rotr64(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // One ASCON round: constant addition, bit-sliced S-box, linear diffusion.
    // Index k of the packed array holds state word xk.
    function automatic logic [4:0][63:0] ascon_round(input logic [4:0][63:0] x,
                                                     input logic [7:0] c);
        logic [4:0][63:0] a;
        logic [4:0][63:0] t;
        a = x;
        a[2][7:0] = a[2][7:0] ^ c;
        a[0] = a[0] ^ a[4];
        a[4] = a[4] ^ a[3];
        a[2] = a[2] ^ a[1];
        t[0] = ~a[0] & a[1];
        t[1] = ~a[1] & a[2];
        t[2] = ~a[2] & a[3];
        t[3] = ~a[3] & a[4];
        t[4] = ~a[4] & a[0];
        a[0] = a[0] ^ t[1];
        a[1] = a[1] ^ t[2];
        a[2] = a[2] ^ t[3];
        a[3] = a[3] ^ t[4];
        a[4] = a[4] ^ t[0];
        a[1] = a[1] ^ a[0];
        a[0] = a[0] ^ a[4];
        a[3] = a[3] ^ a[2];
        a[2] = ~a[2];
        a[0] = a[0] ^ rotr64(a[0], 19) ^ rotr64(a[0], 28);
        a[1] = a[1] ^ rotr64(a[1], 61) ^ rotr64(a[1], 39);
        a[2] = a[2] ^ rotr64(a[2], 1)  ^ rotr64(a[2], 6);
        a[3] = a[3] ^ rotr64(a[3], 10) ^ rotr64(a[3], 17);
        a[4] = a[4] ^ rotr64(a[4], 7)  ^ rotr64(a[4], 41);
        return a;
    endfunction

    // Round constant ((15-i)<<4)|i for the current round index i.
    always_comb begin
        rc_idx_s = RC_BASE + {1'b0, rnd_r};
        rc_s     = {4'd15 - rc_idx_s, rc_idx_s};
    end

    assign round_s = ascon_round({x4_r, x3_r, x2_r, x1_r, x0_r}, rc_s);

    // Handshake and control qualifiers.
    always_comb begin
        start_ok_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        ct_fire_s  = (state_r == ST_WAIT_CT) && ct_valid;
        pt_fire_s  = (state_r == ST_PT_HOLD) && pt_ready;
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) state_s = ST_WAIT_CT;
                else       state_s = state_r;
            end
            ST_WAIT_CT: begin
                if (ct_valid) state_s = ST_PT_HOLD;
                else          state_s = ST_WAIT_CT;
            end
            ST_PT_HOLD: begin
                if (pt_ready) state_s = last_r ? ST_DONE : ST_PERM;
                else          state_s = ST_PT_HOLD;
            end
            ST_PERM: begin
                if (rnd_r == RND_LAST) state_s = ST_WAIT_CT;
                else                   state_s = ST_PERM;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_s;
    end

    // Datapath and registered stream/status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0_r       <= 64'd0;
            x1_r       <= 64'd0;
            x2_r       <= 64'd0;
            x3_r       <= 64'd0;
            x4_r       <= 64'd0;
            rnd_r      <= 3'd0;
            last_r     <= 1'b0;
            pt_data_r  <= 64'd0;
            ct_ready_r <= 1'b0;
            pt_valid_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            // Flags follow the state being entered so they line up with it.
            ct_ready_r <= (state_s == ST_WAIT_CT);
            pt_valid_r <= (state_s == ST_PT_HOLD);
            done_r     <= (state_s == ST_DONE);
            if (start_ok_s) begin
                x0_r <= s0;
                x1_r <= s1;
                x2_r <= s2;
                x3_r <= s3;
                x4_r <= s4;
            end else if (ct_fire_s) begin
                pt_data_r <= x0_r ^ ct_data;
                x0_r      <= ct_data;
                last_r    <= ct_last;
            end else if (state_r == ST_PERM) begin
                x0_r  <= round_s[0];
                x1_r  <= round_s[1];
                x2_r  <= round_s[2];
                x3_r  <= round_s[3];
                x4_r  <= round_s[4];
                rnd_r <= rnd_r + 3'd1;
            end else if (pt_fire_s) begin
                rnd_r <= 3'd0;
            end
        end
    end

    assign ct_ready = ct_ready_r;
    assign pt_valid = pt_valid_r;
    assign pt_data  = pt_data_r;
    assign done     = done_r;
    assign y0       = x0_r;
    assign y1       = x1_r;
    assign y2       = x2_r;
    assign y3       = x3_r;
    assign y4       = x4_r;

endmodule

// File: tb/tb_ascon_ct_decrypt.sv
// ---------------------------------------------------------------------------
// tb_ascon_ct_decrypt
//
// Self-checking bench for ascon_ct_decrypt. A behavioural ASCON-128 model
// (table-driven S-box, init, AD absorption, encryption) produces ciphertext
// from random plaintext; the DUT must recover the plaintext and end in the
// model's pre-finalization state. Also covers reset values, a one-block
// message, backpressure, start while busy, restart from DONE and reset
// during the permutation.
// ---------------------------------------------------------------------------
module tb_ascon_ct_decrypt;

    localparam int          ROUNDS = 6;
    localparam logic [63:0] IV     = 64'h80400c0600000000;
    localparam logic [63:0] K0     = 64'h0001020304050607;
    localparam logic [63:0] K1     = 64'h08090a0b0c0d0e0f;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] s0, s1, s2, s3, s4;
    logic        ct_valid;
    logic        ct_ready;
    logic [63:0] ct_data;
    logic        ct_last;
    logic        pt_valid;
    logic        pt_ready;
    logic [63:0] pt_data;
    logic        done;
    logic [63:0] y0, y1, y2, y3, y4;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] m [5];
    logic [4:0]  sbox_tbl [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    ascon_ct_decrypt #(.ROUNDS(ROUNDS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .s0       (s0),
        .s1       (s1),
        .s2       (s2),
        .s3       (s3),
        .s4       (s4),
        .ct_valid (ct_valid),
        .ct_ready (ct_ready),
        .ct_data  (ct_data),
        .ct_last  (ct_last),
        .pt_valid (pt_valid),
        .pt_ready (pt_ready),
        .pt_data  (pt_data),
        .done     (done),
        .y0       (y0),
        .y1       (y1),
        .y2       (y2),
        .y3       (y3),
        .y4       (y4)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else             n_pass++;
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // Reference permutation: nr rounds with round indices 12-nr .. 11.
    task automatic model_perm(input int nr);
        logic [4:0] col;
        logic [4:0] o;
        int         i;
        for (int r = 0; r < nr; r++) begin
            i = 12 - nr + r;
            m[2] = m[2] ^ 64'(((15 - i) << 4) | i);
            for (int b = 0; b < 64; b++) begin
                col = {m[0][b], m[1][b], m[2][b], m[3][b], m[4][b]};
                o   = sbox_tbl[col];
                m[0][b] = o[4];
                m[1][b] = o[3];
                m[2][b] = o[2];
                m[3][b] = o[1];
                m[4][b] = o[0];
            end
            m[0] = m[0] ^ rotr(m[0], 19) ^ rotr(m[0], 28);
            m[1] = m[1] ^ rotr(m[1], 61) ^ rotr(m[1], 39);
            m[2] = m[2] ^ rotr(m[2], 1)  ^ rotr(m[2], 6);
            m[3] = m[3] ^ rotr(m[3], 10) ^ rotr(m[3], 17);
            m[4] = m[4] ^ rotr(m[4], 7)  ^ rotr(m[4], 41);
        end
    endtask

    // ASCON-128 init + 3 AD words (+ padding block) + domain separation.
    task automatic model_prepare(input logic [63:0] n0, input logic [63:0] n1);
        m[0] = IV; m[1] = K0; m[2] = K1; m[3] = n0; m[4] = n1;
        model_perm(12);
        m[3] = m[3] ^ K0;
        m[4] = m[4] ^ K1;
        for (int a = 0; a < 3; a++) begin
            m[0] = m[0] ^ rand64();
            model_perm(6);
        end
        m[0] = m[0] ^ 64'h8000000000000000;
        model_perm(6);
        m[4] = m[4] ^ 64'd1;
    endtask

    // Pulse start with the model state; called at a negedge.
    task automatic do_start();
        s0 = m[0]; s1 = m[1]; s2 = m[2]; s3 = m[3]; s4 = m[4];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s0 = rand64(); s1 = rand64(); s2 = rand64(); s3 = rand64(); s4 = rand64();
        check_eq("start_ct_ready", {63'd0, ct_ready}, 64'd1);
        check_eq("start_done_low", {63'd0, done}, 64'd0);
    endtask

    // One ciphertext word. mode: 0 normal, 1 start pulse in PERM, 2 reset in PERM.
    task automatic xfer(input logic [63:0] ct, input bit last, input int stall,
                        input logic [63:0] exp_pt, input int mode);
        int n;
        logic [63:0] held;
        repeat ($urandom_range(2)) @(negedge clk);
        ct_valid = 1'b1; ct_data = ct; ct_last = last;
        n = 0;
        while (!ct_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            check_eq("ct_ready_timeout", {63'd0, ct_ready}, 64'd1);
            ct_valid = 1'b0;
            return;
        end
        @(negedge clk);
        ct_valid = 1'b0; ct_data = rand64(); ct_last = $urandom_range(1) == 1;
        check_eq("pt_valid", {63'd0, pt_valid}, 64'd1);
        check_eq("pt_data", pt_data, exp_pt);
        check_eq("hold_ct_ready", {63'd0, ct_ready}, 64'd0);
        held = pt_data;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check_eq("stall_pt_valid", {63'd0, pt_valid}, 64'd1);
            check_eq("stall_pt_data", pt_data, held);
            check_eq("stall_ct_ready", {63'd0, ct_ready}, 64'd0);
        end
        pt_ready = 1'b1;
        @(negedge clk);
        pt_ready = 1'b0;
        check_eq("pt_valid_drop", {63'd0, pt_valid}, 64'd0);
        if (last) begin
            check_eq("done_after_last", {63'd0, done}, 64'd1);
            check_eq("ct_ready_after_last", {63'd0, ct_ready}, 64'd0);
            return;
        end
        check_eq("done_mid_msg", {63'd0, done}, 64'd0);
        n = 0;
        while (!ct_ready && n < 20) begin
            if (mode == 2 && n == 2) begin
                rst_n = 1'b0;
                #1;
                check_eq("rst_ct_ready", {63'd0, ct_ready}, 64'd0);
                check_eq("rst_pt_valid", {63'd0, pt_valid}, 64'd0);
                check_eq("rst_done", {63'd0, done}, 64'd0);
                check_eq("rst_pt_data", pt_data, 64'd0);
                check_eq("rst_y_or", y0 | y1 | y2 | y3 | y4, 64'd0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (mode == 1 && n == 2) begin
                start = 1'b1;
                s0 = rand64(); s1 = rand64(); s2 = rand64(); s3 = rand64(); s4 = rand64();
            end
            @(negedge clk);
            start = 1'b0;
            n++;
        end
        check_eq("ct_ready_gap", 64'(n), 64'(ROUNDS));
    endtask

    // Full message: prepare model, start DUT, stream words, compare final state.
    task automatic run_msg(input int nw, input int first_stall, input int mode);
        logic [63:0] pt_w [4];
        logic [63:0] ct_w [4];
        model_prepare(rand64(), rand64());
        do_start();
        for (int j = 0; j < nw; j++) begin
            pt_w[j] = rand64();
            ct_w[j] = m[0] ^ pt_w[j];
            m[0]    = ct_w[j];
            if (j < nw - 1) model_perm(ROUNDS);
        end
        for (int j = 0; j < nw; j++) begin
            xfer(ct_w[j], j == nw - 1, (j == 0) ? first_stall : int'($urandom_range(3)),
                 pt_w[j], (j == 0) ? mode : 0);
            if (mode == 2) begin
                repeat (3) begin
                    @(negedge clk);
                    check_eq("post_rst_ct_ready", {63'd0, ct_ready}, 64'd0);
                end
                check_eq("post_rst_done", {63'd0, done}, 64'd0);
                check_eq("post_rst_y0", y0, 64'd0);
                return;
            end
        end
        check_eq("msg_done", {63'd0, done}, 64'd1);
        check_eq("y0", y0, m[0]);
        check_eq("y1", y1, m[1]);
        check_eq("y2", y2, m[2]);
        check_eq("y3", y3, m[3]);
        check_eq("y4", y4, m[4]);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; ct_valid = 1'b0; ct_data = 64'd0; ct_last = 1'b0;
        pt_ready = 1'b0;
        s0 = 64'd0; s1 = 64'd0; s2 = 64'd0; s3 = 64'd0; s4 = 64'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("reset_ct_ready", {63'd0, ct_ready}, 64'd0);
        check_eq("reset_pt_valid", {63'd0, pt_valid}, 64'd0);
        check_eq("reset_done", {63'd0, done}, 64'd0);
        check_eq("reset_pt_data", pt_data, 64'd0);
        check_eq("reset_y_or", y0 | y1 | y2 | y3 | y4, 64'd0);
        repeat (3) @(negedge clk);
        check_eq("idle_ct_ready", {63'd0, ct_ready}, 64'd0);

        // One-block message from an all-zero state.
        for (int k = 0; k < 5; k++) m[k] = 64'd0;
        do_start();
        xfer(64'h0123456789abcdef, 1'b1, 0, 64'h0123456789abcdef, 0);
        check_eq("oneblk_y0", y0, 64'h0123456789abcdef);
        check_eq("oneblk_y_rest", y1 | y2 | y3 | y4, 64'd0);

        // Multi-block round trip with 5-cycle backpressure on the first word.
        run_msg(3, 5, 0);
        // Restart from DONE.
        run_msg(3, 0, 0);
        // Start pulse during PERM must be ignored.
        run_msg(3, int'($urandom_range(3)), 1);
        // Reset in the third PERM cycle, then recover.
        run_msg(2, 0, 2);
        run_msg(3, 2, 0);
        // A few random-length messages.
        for (int r = 0; r < 4; r++) run_msg(int'($urandom_range(1, 4)), int'($urandom_range(4)), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
